rr_mux_arbiter_4: RTL and testbench
===================================

# rr_mux_arbiter_4

Round-robin arbiter that shares one 4:1 data mux between four valid/ready requesters. It drives a single registered output channel. A granted requester keeps the mux until it sends a beat with `in_last` asserted, so multi-beat packets are never interleaved. The block sits between four producers and one downstream consumer, and exposes the active mux select for debug and for downstream tagging.

## Interface
- `W`, default 4: data width per requester.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronous to `clk` at the system level.
- `in_valid`  in  4: per-requester valid; bit i belongs to requester i.
- `in_last`  in  4: per-requester end-of-packet flag; meaningful only with the matching valid.
- `in_data`  in  4×W: packed array, `in_data[i]` is requester i's data.
- `in_ready`  out  4: per-requester ready; at most one bit is high in any cycle.
- `out_valid`  out  1: output register holds a beat.
- `out_data`  out  W: registered muxed data.
- `out_last`  out  1: registered `in_last` of the forwarded beat.
- `out_sel`  out  2: index of the requester whose beat is in the output register.
- `out_ready`  in  1: downstream accepts a beat when `out_valid && out_ready`.
- `busy`  out  1: high while in LOCKED state.

## Operation
- `load_en = !out_valid || out_ready`. This is a single output register with no skid buffer.
- The state machine has two states, IDLE and LOCKED. It also holds `ptr` (2 bits, highest-priority requester) and `owner` (2 bits).
- In IDLE:
  - The candidate is the first i with `in_valid[i]` set, scanning `ptr, ptr+1, … ptr+3` mod 4.
  - If a candidate exists and `load_en`: `in_ready[cand]=1`, the beat loads, `out_sel<=cand`.
  - If the beat has `in_last=0`: go to LOCKED with `owner<=cand`.
  - If the beat has `in_last=1`: stay IDLE, `ptr<=cand+1`.
- In LOCKED:
  - Only `owner` is considered; other valids are ignored.
  - `in_ready[owner] = load_en`.
  - On an accepted beat with `in_last=1`: go to IDLE, `ptr<=owner+1`.
  - If the owner's valid is low, the state holds; there is no timeout.
- Transfer on the input side: `in_valid[i] && in_ready[i]`. `in_ready` does not depend on `in_valid[i]` of the same requester in LOCKED; in IDLE it does.
- Output: the register loads on an input transfer. It clears `out_valid` when `out_ready` is high and no new load occurs. Load and drain in the same cycle keeps `out_valid=1` with the new beat.
- `ptr` wraps 3→0. A single-beat grant to requester 3 gives `ptr=0`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_sel=0`, `busy=0`, `in_ready=0`. Internally the state is IDLE, `ptr=0`, `owner=0`.
- Latency is 1 cycle: a beat accepted at edge n appears on `out_*` after edge n.
- Full throughput of 1 beat/cycle while `out_ready=1`. With a one-deep register and `out_ready=0`, at most one beat is held.
- `in_ready` is combinational from state, `ptr`, `in_valid` and `out_ready`. There is no combinational path from `in_data` to any output.
- Reset asserted mid-packet immediately returns to IDLE and drops `out_valid`. The partial packet is discarded; the requester must restart.
- Simultaneous requests from all four with `in_last=1` and `out_ready=1` produce grant order 0,1,2,3,0… on consecutive cycles.

## Structure
- Package `rr_mux_arbiter_pkg` holds:
  - `typedef enum logic {IDLE, LOCKED} arb_state_t`;
  - `localparam N_REQ = 4`;
  - `typedef logic [1:0] req_idx_t`.
- Sub-module `rr_pick_4`: purely combinational first-set search from `ptr` over 4 valids. It returns `found` and `idx`.
- The top level holds the FSM, `ptr`/`owner` registers, the 4:1 data mux (if/else on index) and the output register.

## Test plan
- Reset then idle: `in_valid=0000` for 10 cycles → `out_valid=0` throughout, `in_ready=0000`, `out_sel=0`.
- All four valid, every beat `last=1`, data i = 4'hA+i, `out_ready=1` → outputs A,B,C,D,A with `out_sel` 0,1,2,3,0; `in_ready` is one-hot each cycle.
- Requester 2 sends a 3-beat packet (5,6,7, last on 7) while requesters 0 and 3 are valid → output 5,6,7 uninterrupted, `busy=1` for 2 cycles, next grant goes to 3 and then 0.
- Backpressure: `out_ready=0` for 3 cycles with requester 1 valid (data 9) → `out_data=9` held and `in_ready=0000` after the first load. On `out_ready=1` the next beat loads the same cycle.
- Wrap: only requester 3 valid (data E, last) → `ptr` becomes 0. Then requesters 0 and 3 are valid → requester 0 is granted first.
- Async reset mid-packet: assert `rst_n=0` between clock edges during LOCKED → `out_valid=0` and `busy=0` before the next edge. After release, grant restarts from `ptr=0`.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
//   arb_state_t : FSM encoding (IDLE = free to pick, LOCKED = packet in flight)
//   N_REQ       : number of requesters sharing the mux
//   req_idx_t   : requester index; 2 bits so +1 wraps 3 -> 0 for free
package rr_mux_arbiter_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  localparam int N_REQ = 4;

  typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/rr_mux_arbiter_4_pick.sv
// Purely combinational round-robin search: the first set bit of valid,
// scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
// Ports:
//   valid : per-requester request bits
//   ptr   : highest-priority requester this cycle
//   found : some bit of valid is set
//   idx   : winning requester (equals ptr when found is low)
module rr_pick_4
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] valid,
  input  req_idx_t         ptr,
  output logic             found,
  output req_idx_t         idx
);

  req_idx_t probe;

  // Walk from the lowest-priority offset back to ptr so that the
  // highest-priority hit is the one written last.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    probe = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      probe = ptr + req_idx_t'(k);
      if (valid[probe]) begin
        found = 1'b1;
        idx   = probe;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter sharing one 4:1 data mux among four valid/ready
// requesters, feeding a single registered output channel. A granted
// requester keeps the mux until it sends a beat with in_last set, so
// multi-beat packets are never interleaved.
//
// Handshake: a beat moves on any channel when valid && ready in the same
// cycle. Producers hold valid/data/last until accepted; ready may depend on
// valid (in IDLE) but no output depends combinationally on in_data.
//
// Ports:
//   clk, rst_n : rising-edge clock, async active-low reset
//   in_valid   : per-requester valid (bit i = requester i)
//   in_last    : per-requester end-of-packet flag
//   in_data    : packed per-requester data, in_data[i] is requester i
//   in_ready   : per-requester ready, at most one bit high
//   out_valid  : output register holds a beat
//   out_data   : registered muxed data
//   out_last   : registered in_last of the forwarded beat
//   out_sel    : requester index of the beat in the output register
//   out_ready  : downstream accept
//   busy       : FSM is LOCKED (packet in progress) -- exposes the state
module rr_mux_arbiter_4
  import rr_mux_arbiter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         in_valid,
  input  logic [N_REQ-1:0]         in_last,
  input  logic [N_REQ-1:0][W-1:0]  in_data,
  output logic [N_REQ-1:0]         in_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic                     out_last,
  output req_idx_t                 out_sel,
  input  logic                     out_ready,
  output logic                     busy
);

  arb_state_t state, state_d;
  req_idx_t   ptr, ptr_d;
  req_idx_t   owner, owner_d;

  logic       cand_found;
  req_idx_t   cand;
  req_idx_t   sel_idx;
  logic       load_en;
  logic       xfer;
  logic       sel_last;
  logic [W-1:0] mux_data;

  rr_pick_4 u_pick (
    .valid (in_valid),
    .ptr   (ptr),
    .found (cand_found),
    .idx   (cand)
  );

  // One output register, no skid: accept only if it is empty or draining.
  assign load_en = !out_valid || out_ready;

  // While LOCKED only the owner is steered through the mux.
  assign sel_idx  = (state == LOCKED) ? owner : cand;
  assign sel_last = in_last[sel_idx];
  assign busy     = (state == LOCKED);

  always_comb begin
    if (sel_idx == 2'd0)      mux_data = in_data[0];
    else if (sel_idx == 2'd1) mux_data = in_data[1];
    else if (sel_idx == 2'd2) mux_data = in_data[2];
    else                      mux_data = in_data[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      owner <= owner_d;
    end
  end

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    owner_d  = owner;
    in_ready = '0;
    xfer     = 1'b0;
    case (state)
      IDLE: begin
        if (cand_found && load_en) begin
          in_ready[cand] = 1'b1;
          xfer           = 1'b1;
          if (sel_last) begin
            ptr_d = cand + 2'd1;
          end else begin
            state_d = LOCKED;
            owner_d = cand;
          end
        end
      end
      LOCKED: begin
        // Ready to the owner regardless of its valid; other valids ignored.
        in_ready[owner] = load_en;
        xfer            = load_en && in_valid[owner];
        if (xfer && sel_last) begin
          state_d = IDLE;
          ptr_d   = owner + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= sel_last;
      out_sel   <= sel_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Bench for rr_mux_arbiter_4: a per-cycle vector table (inputs plus the
// expected in_ready / out_valid / busy) driven on the falling edge, with a
// scoreboard queue holding the beats each accepted input should produce on
// the output; plus a hand-written async-reset-mid-packet sequence.
module tb_rr_mux_arbiter_4;

  localparam int W = 4;

  logic             clk;
  logic             rst_n;
  logic [3:0]       in_valid;
  logic [3:0]       in_last;
  logic [3:0][W-1:0] in_data;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic [1:0]       out_sel;
  logic             out_ready;
  logic             busy;

  rr_mux_arbiter_4 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [15:0] data;     // {d3, d2, d1, d0}
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_ovalid;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  // entry = {sel[1:0], last, data[W-1:0]}
  logic [W+2:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] valid, input logic [3:0] last,
                         input logic [15:0] data, input logic ordy,
                         input logic [3:0] exp_ready, input logic exp_ovalid,
                         input logic exp_busy);
    vec_t v;
    v.valid = valid; v.last = last; v.data = data; v.ordy = ordy;
    v.exp_ready = exp_ready; v.exp_ovalid = exp_ovalid; v.exp_busy = exp_busy;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] valid, input logic [3:0] last,
                       input logic [15:0] data, input logic ordy);
    in_valid  = valid;
    in_last   = last;
    in_data   = data;
    out_ready = ordy;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W+2:0] e;
    logic [15:0]  d;
    int           idx;

    drive(4'b0, 4'b0, 16'h0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data",  out_data,  '0);
    check("reset out_last",  out_last,  1'b0);
    check("reset out_sel",   out_sel,   2'd0);
    check("reset busy",      busy,      1'b0);
    check("reset in_ready",  in_ready,  4'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle: nothing valid for 10 cycles
    for (int i = 0; i < 10; i++) add_vec(4'b0, 4'b0, 16'h0, 1'b1, 4'b0, 1'b0, 1'b0);
    // all four valid, single-beat packets: grants 0,1,2,3,0
    add_vec(4'b1111, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b0, 1'b0);
    add_vec(4'b1111, 4'b1111, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 1'b0);
    add_vec(4'b1111, 4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 1'b0);
    add_vec(4'b1111, 4'b1111, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 1'b0);
    add_vec(4'b1111, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 1'b0);
    add_vec(4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    // ptr=1: requester 2 sends 5,6,7 while 0 and 3 wait; then 3, then 0
    add_vec(4'b1101, 4'b1001, 16'h3501, 1'b1, 4'b0100, 1'b0, 1'b0);
    add_vec(4'b1101, 4'b1001, 16'h3601, 1'b1, 4'b0100, 1'b1, 1'b1);
    add_vec(4'b1101, 4'b1101, 16'h3701, 1'b1, 4'b0100, 1'b1, 1'b1);
    add_vec(4'b1001, 4'b1001, 16'h3001, 1'b1, 4'b1000, 1'b1, 1'b0);
    add_vec(4'b0001, 4'b0001, 16'h0001, 1'b1, 4'b0001, 1'b1, 1'b0);
    add_vec(4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    // backpressure: requester 1 beat 9 held 3 cycles, beat 8 loads on release
    add_vec(4'b0010, 4'b0010, 16'h0090, 1'b0, 4'b0010, 1'b0, 1'b0);
    add_vec(4'b0010, 4'b0010, 16'h0080, 1'b0, 4'b0000, 1'b1, 1'b0);
    add_vec(4'b0010, 4'b0010, 16'h0080, 1'b0, 4'b0000, 1'b1, 1'b0);
    add_vec(4'b0010, 4'b0010, 16'h0080, 1'b1, 4'b0010, 1'b1, 1'b0);
    add_vec(4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    // wrap: requester 3 alone (ptr -> 0), then 0 and 3: 0 wins, then 3
    add_vec(4'b1000, 4'b1000, 16'hE000, 1'b1, 4'b1000, 1'b0, 1'b0);
    add_vec(4'b1001, 4'b1001, 16'hF002, 1'b1, 4'b0001, 1'b1, 1'b0);
    add_vec(4'b1000, 4'b1000, 16'hF000, 1'b1, 4'b1000, 1'b1, 1'b0);
    add_vec(4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    add_vec(4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].ordy);
      #1;
      check($sformatf("row%0d in_ready", i),  in_ready,  vecs[i].exp_ready);
      check($sformatf("row%0d out_valid", i), out_valid, vecs[i].exp_ovalid);
      check($sformatf("row%0d busy", i),      busy,      vecs[i].exp_busy);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL row%0d beat: got %0h expected none", i, {out_sel, out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          checks--;
          check($sformatf("row%0d beat", i), {out_sel, out_last, out_data}, e);
        end
      end
      if ((vecs[i].valid & vecs[i].exp_ready) != 4'b0) begin
        idx = 0;
        for (int b = 0; b < 4; b++) if (vecs[i].exp_ready[b]) idx = b;
        d = vecs[i].data;
        exp_q.push_back({2'(idx), vecs[i].last[idx], d[idx*4 +: 4]});
      end
    end
    check("scoreboard drained", exp_q.size(), 0);

    // async reset mid-packet (ptr is 0 here)
    @(negedge clk);
    drive(4'b0100, 4'b0000, 16'h0400, 1'b1);
    #1 check("lock in_ready", in_ready, 4'b0100);
    @(posedge clk);
    #2;
    check("lock busy",      busy,      1'b1);
    check("lock out_valid", out_valid, 1'b1);
    check("lock out_data",  out_data,  4'h4);
    #1;
    rst_n = 1'b0;
    in_valid = 4'b0;
    #1;
    check("async out_valid", out_valid, 1'b0);
    check("async busy",      busy,      1'b0);
    check("async in_ready",  in_ready,  4'b0);
    check("async out_sel",   out_sel,   2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1101, 4'b1111, 16'h3401, 1'b1);
    #1 check("restart in_ready", in_ready, 4'b0001);
    @(posedge clk);
    #1;
    check("restart out_valid", out_valid, 1'b1);
    check("restart out_sel",   out_sel,   2'd0);
    check("restart out_data",  out_data,  4'h1);
    @(negedge clk);
    drive(4'b0, 4'b0, 16'h0, 1'b1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard bound so the run always ends
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
